// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INSTR_W / ADDR_W : instruction and byte-address widths
//   fsm_state_e      : fetch FSM states (IDLE, FETCH, END)
package instr_fetch_unit_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    END   = 2'd2
  } fsm_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH x W circular FIFO with synchronous flush.
//   push_i/din_i : write din_i at tail (accepted when not full, or full with pop)
//   pop_i        : drop head entry (ignored when empty)
//   flush_i      : discard all entries; overrides push and pop
//   dout_o       : head entry (combinational read)
//   count_o, full_o, empty_o : occupancy
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [PW:0]             cnt_q;
  logic                    do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  // Writing the head slot while full is safe: the head is read before the edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + PTR_ONE;
      end
      if (do_pop) rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential fetch from a combinational instruction
// memory into a prefetch buffer, with redirect and end-of-memory halt.
//   imem_pc / imem_instr          : instruction memory address / data
//   redirect_valid / redirect_pc  : flush and restart fetch at a new address
//   out_valid/out_ready/out_instr/out_pc : head of buffer to decode
//   fetch_done : halted at end of memory; fifo_count : buffered entries
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
  parameter logic [ADDR_W-1:0] IMEM_LIMIT = 16'd32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_W-1:0]      imem_pc,
  input  logic [INSTR_W-1:0]     imem_instr,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  output logic                   fetch_done,
  output logic [$clog2(DEPTH):0] fifo_count
);
  fsm_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_adv, redir_pc;
  logic                push, pop, fifo_full, fifo_empty;

  assign imem_pc    = {pc_q[ADDR_W-1:1], 1'b0};
  assign pc_adv     = imem_pc + 16'd2;          // 16-bit modulo
  assign redir_pc   = {redirect_pc[ADDR_W-1:1], 1'b0};
  assign out_valid  = !fifo_empty;
  assign fetch_done = (state_q == END);

  // Redirect flushes the buffer, so that cycle's push and pop are suppressed.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = (state_q == FETCH) && (!fifo_full || pop) && !redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = redir_pc;
      state_d = (redir_pc < IMEM_LIMIT) ? FETCH : END;
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: if (push) begin
          pc_d = pc_adv;
          if (pc_adv >= IMEM_LIMIT) state_d = END;
        end
        END:     state_d = END;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   ({imem_pc, imem_instr}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .dout_o  ({out_pc, out_instr}),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [15:0] LIMIT = 16'd32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_pc, imem_instr, redirect_pc, out_instr, out_pc;
  logic        redirect_valid, out_valid, out_ready, fetch_done;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  // Instruction memory contents: fixed words at 0 and 2, hash elsewhere.
  function automatic logic [15:0] instr_of(input logic [15:0] a);
    if (a == 16'h0000) return 16'h8180;
    if (a == 16'h0002) return 16'h0530;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction
  assign imem_instr = instr_of(imem_pc);

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .IMEM_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_done(fetch_done), .fifo_count(fifo_count)
  );

  typedef struct packed { logic [15:0] pc; logic [15:0] instr; } ent_t;
  ent_t        exp_q[$];
  int          n_cmp = 0, n_err = 0;
  logic [15:0] last_pop_pc = 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected decode stream after a (re)start: consecutive halfwords from the
  // start address up to the end of instruction memory.
  task automatic expect_from(input logic [15:0] start);
    exp_q.delete();
    for (int a = int'({start[15:1], 1'b0}); a < int'(LIMIT); a += 2)
      exp_q.push_back({16'(a), instr_of(16'(a))});
  endtask

  // Monitor: each handshake pops the scoreboard; a stalled head must hold.
  logic prev_hold = 1'b0;
  ent_t prev_head;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_head", {out_pc, out_instr}, prev_head);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got pc %h instr %h expected nothing", out_pc, out_instr);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          if ({out_pc, out_instr} !== e) begin
            n_err++;
            $display("FAIL pop: got %h/%h expected %h/%h", out_pc, out_instr, e.pc, e.instr);
          end
          last_pop_pc = out_pc;
        end
      end
      prev_hold = out_valid && !out_ready && !redirect_valid;
      prev_head = {out_pc, out_instr};
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0; out_ready = rdy; redirect_valid = 1'b0; redirect_pc = '0;
    exp_q.delete();
    step(); step();
    expect_from(16'h0000);
    rst_n = 1'b1;
  endtask

  initial begin
    out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_done", {31'd0, fetch_done}, 32'd0);
    chk("rst_head", {out_pc, out_instr}, 32'd0);
    chk("rst_imem_pc", {16'd0, imem_pc}, 32'd0);

    // First valid two edges after release, in address order.
    do_reset(1'b1);
    step();
    chk("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
    chk("first_head", {out_pc, out_instr}, {16'h0000, 16'h8180});
    step();
    chk("second_head", {out_pc, out_instr}, {16'h0002, 16'h0530});

    // Back-pressure saturates the buffer and stalls the PC.
    do_reset(1'b0);
    repeat (11) step();
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_imem_pc", {16'd0, imem_pc}, 32'h0008);
    chk("full_head_pc", {16'd0, out_pc}, 32'h0000);

    // Redirect to an odd target with three entries buffered.
    do_reset(1'b0);
    repeat (4) step();
    chk("pre_redir_count", {29'd0, fifo_count}, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 16'h0007; expect_from(16'h0007);
    step();
    redirect_valid = 1'b0;
    chk("redir_count", {29'd0, fifo_count}, 32'd0);
    chk("redir_imem_pc", {16'd0, imem_pc}, 32'h0006);
    step();
    chk("redir_head", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, 16'h0006});

    // Free-run to end of memory.
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !(fetch_done && !out_valid); i++) step();
    chk("end_done", {31'd0, fetch_done}, 32'd1);
    chk("end_last_pc", {16'd0, last_pop_pc}, 32'h001E);
    chk("end_valid", {31'd0, out_valid}, 32'd0);
    chk("end_sb_empty", exp_q.size(), 32'd0);
    repeat (3) step();
    chk("end_stays_empty", {31'd0, out_valid}, 32'd0);

    // Redirect out of END resumes fetching.
    redirect_valid = 1'b1; redirect_pc = 16'h0004; expect_from(16'h0004);
    step();
    redirect_valid = 1'b0;
    chk("resume_done", {31'd0, fetch_done}, 32'd0);
    step();
    chk("resume_head", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, 16'h0004});

    // Asynchronous reset between edges with a full buffer.
    out_ready = 1'b0;
    repeat (6) step();
    chk("pre_arst_count", {29'd0, fifo_count}, 32'd4);
    #2 rst_n = 1'b0; exp_q.delete();
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count", {29'd0, fifo_count}, 32'd0);
    step();
    expect_from(16'h0000); rst_n = 1'b1;

    // Randomized traffic: back-pressure, redirects (some past the limit), resets.
    for (int i = 0; i < 3000; i++) begin
      redirect_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0; exp_q.delete();
        #1 chk("rnd_arst_valid", {31'd0, out_valid}, 32'd0);
        step();
        expect_from(16'h0000); rst_n = 1'b1;
      end else begin
        if ($urandom_range(0, 19) == 0) begin
          redirect_valid = 1'b1;
          redirect_pc = 16'($urandom_range(0, 40));
          expect_from(redirect_pc);
        end
        step();
      end
    end

    redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (60) step();
    chk("drain_sb_empty", exp_q.size(), 32'd0);
    chk("drain_done", {31'd0, fetch_done}, 32'd1);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 4, prefetch buffer entries (power of two, >=2)
- RESET_PC, 16'h0000, first fetch address after reset
- IMEM_LIMIT, 16'd32, first byte address beyond the instruction memory
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- imem_pc, out, 16, byte address presented to the instruction memory
- imem_instr, in, 16, instruction returned combinationally for imem_pc
- redirect_valid, in, 1, branch/jump redirect request
- redirect_pc, in, 16, redirect target byte address
- out_valid, out, 1, head entry available to decode
- out_ready, in, 1, decode accepts head entry
- out_instr, out, 16, head instruction
- out_pc, out, 16, byte address of head instruction
- fetch_done, out, 1, fetch halted at end of memory
- fifo_count, out, $clog2(DEPTH)+1, current entries

Function
REQ-003 The unit SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The FSM SHALL have states IDLE, FETCH and END.
REQ-005 Reset SHALL enter IDLE; IDLE SHALL go to FETCH on the next edge unconditionally.
REQ-006 imem_pc SHALL equal the internal fetch PC at all times, bit 0 forced to 0.
REQ-007 In FETCH, push SHALL occur when the buffer has space or a pop occurs the same cycle. Each push SHALL write {fetch PC, imem_instr} at the tail and advance the PC by 2.
REQ-008 The FSM SHALL go from FETCH to END on the edge where the advanced PC is >= IMEM_LIMIT. No push SHALL occur in END. fetch_done SHALL be 1 only in END.
REQ-009 PC arithmetic SHALL be 16-bit modulo; 16'hFFFE+2 SHALL give 16'h0000.
REQ-010 out_valid SHALL be 1 iff fifo_count != 0. out_instr and out_pc SHALL show the head entry.
REQ-011 A pop SHALL occur when out_valid && out_ready. While out_valid=1, the head SHALL stay stable until popped.
REQ-012 redirect_valid, from any state, SHALL at the edge:
- flush all entries (count=0)
- load PC with redirect_pc with bit 0 cleared
- suppress that cycle's push and pop
- enter FETCH if the target is < IMEM_LIMIT, else END
REQ-013 Redirect SHALL take priority over push, pop and the END transition in the same cycle.
REQ-014 Latency: an instruction fetched at edge N SHALL show out_valid=1 after edge N. The first valid after reset SHALL be 2 edges after rst_n deasserts.
REQ-015 Full: at count=DEPTH with no pop, PC and buffer SHALL hold. Empty: out_valid=0, and out_ready SHALL be ignored.
REQ-016 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-017 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-018 Reset SHALL set state=IDLE, PC=RESET_PC, fifo_count=0, pointers=0, out_valid=0, fetch_done=0, out_instr=0, out_pc=0.
REQ-019 Reset asserted mid-operation SHALL discard all buffered entries and any pending redirect immediately, without waiting for clk.

Structure
REQ-020 A shared package SHALL hold the FSM state enum (IDLE, FETCH, END), the instruction width (16) and the address width (16).
REQ-021 The buffer SHALL be one sub-module, fetch_fifo: DEPTH x 32 bits ({pc, instr}), with push, pop, flush, count, full and empty.

Verification
REQ-022 Reset release with out_ready=1, memory words 16'h8180, 16'h0530:
- out_valid rises 2 edges after release
- out_pc=0, out_instr=16'h8180, then out_pc=2, out_instr=16'h0530
REQ-023 Hold out_ready=0 for 10 cycles:
- fifo_count saturates at 4
- imem_pc holds at 16'h0008
- head stays out_pc=0
REQ-024 Redirect to 16'h0007 with 3 entries buffered:
- next cycle fifo_count=0, imem_pc=16'h0006
- following valid shows out_pc=6
REQ-025 Free-run with out_ready=1 and IMEM_LIMIT=32:
- last popped out_pc=16'h001E
- fetch_done=1
- out_valid=0 thereafter
REQ-026 In END, redirect to 16'h0004: fetch_done drops, FETCH resumes, out_pc=4 appears.
REQ-027 Assert rst_n=0 between clock edges with a full buffer: out_valid=0 and fifo_count=0 immediately.
